// File: rtl/lvtram_write_queue_if.sv
// Enqueue lanes (producer side) and RAM write ports (RAM side) of the LVT RAM write queue.
// master = producer/RAM harness, slave = the queue itself.
interface lvtram_write_queue_if #(
    parameter int RAM_WIDTH         = 64,
    parameter int RAM_DEPTH         = 128,
    parameter int NUM_OF_ENQ_PORT   = 2,
    parameter int NUM_OF_WRITE_PORT = 2
);
    localparam int RAM_WIDTH_BYTE = RAM_WIDTH / 8;
    localparam int RAM_IDX_WIDTH  = $clog2(RAM_DEPTH);

    logic [NUM_OF_ENQ_PORT-1:0]                        enq_valid;
    logic [NUM_OF_ENQ_PORT-1:0][RAM_IDX_WIDTH-1:0]     enq_idx;
    logic [NUM_OF_ENQ_PORT-1:0][RAM_WIDTH-1:0]         enq_data;
    logic [NUM_OF_ENQ_PORT-1:0][RAM_WIDTH_BYTE-1:0]    enq_mask;
    logic                                              enq_ready;

    logic [NUM_OF_WRITE_PORT-1:0]                      w_en;
    logic [NUM_OF_WRITE_PORT-1:0][RAM_IDX_WIDTH-1:0]   w_ram_idx;
    logic [NUM_OF_WRITE_PORT-1:0][RAM_WIDTH-1:0]       w_data;
    logic [NUM_OF_WRITE_PORT-1:0][RAM_WIDTH_BYTE-1:0]  w_mask;

    modport master (
        output enq_valid, enq_idx, enq_data, enq_mask,
        input  enq_ready,
        input  w_en, w_ram_idx, w_data, w_mask
    );

    modport slave (
        input  enq_valid, enq_idx, enq_data, enq_mask,
        output enq_ready,
        output w_en, w_ram_idx, w_data, w_mask
    );
endinterface

// File: rtl/lvtram_write_queue.sv
// In-order byte-masked write buffer feeding the LVT RAM write ports, with a zero-fill clear engine.
// Optional perf counters (conflict_cycles, full_cycles) are built when LVTRAM_WQ_PERF_EN is defined.
module lvtram_write_queue #(
    parameter  int RAM_WIDTH         = 64,
    parameter  int RAM_DEPTH         = 128,
    parameter  int NUM_OF_ENQ_PORT   = 2,
    parameter  int NUM_OF_WRITE_PORT = 2,
    parameter  int QUEUE_DEPTH       = 8,
    localparam int RAM_WIDTH_BYTE    = RAM_WIDTH / 8,
    localparam int RAM_IDX_WIDTH     = $clog2(RAM_DEPTH),
    localparam int CNT_WIDTH         = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    lvtram_write_queue_if.slave    io_wq,
    input  logic                   clear_req,
    output logic                   clear_done,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   count
`ifdef LVTRAM_WQ_PERF_EN
    ,
    output logic [31:0]            conflict_cycles,
    output logic [31:0]            full_cycles
`endif
);
    localparam int PTR_WIDTH = $clog2(QUEUE_DEPTH);
    localparam int CLR_WIDTH = $clog2(RAM_DEPTH + NUM_OF_WRITE_PORT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [PTR_WIDTH-1:0]  r_head;
    logic [PTR_WIDTH-1:0]  r_tail;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CLR_WIDTH-1:0]  r_clear_ptr;

    logic [RAM_IDX_WIDTH-1:0]  r_q_idx  [QUEUE_DEPTH];
    logic [RAM_WIDTH-1:0]      r_q_data [QUEUE_DEPTH];
    logic [RAM_WIDTH_BYTE-1:0] r_q_mask [QUEUE_DEPTH];

    logic                                         w_drain_state;
    logic                                         w_enq_ready;
    logic [NUM_OF_ENQ_PORT-1:0]                   w_enq_fire;
    logic [NUM_OF_ENQ_PORT-1:0][PTR_WIDTH-1:0]    w_wr_ptr;
    logic [CNT_WIDTH-1:0]                         w_enq_num;
    logic [NUM_OF_WRITE_PORT-1:0][PTR_WIDTH-1:0]  w_rd_ptr;
    logic [NUM_OF_WRITE_PORT-1:0]                 w_emit;
    logic [CNT_WIDTH-1:0]                         w_drain_num;
    logic                                         w_clear_last;

    assign w_drain_state = (r_state == ST_IDLE) || (r_state == ST_DRAIN);

    // Readiness looks only at registered occupancy so it never depends on this cycle's drain.
    assign w_enq_ready = (r_state == ST_IDLE) &&
                         ((CNT_WIDTH'(QUEUE_DEPTH) - r_count) >= CNT_WIDTH'(NUM_OF_ENQ_PORT));

    // Valid lanes are packed in ascending lane order behind the tail.
    // NOTE: always_comb uses blocking assignments; the running sum must be visible to the next lane.
    always_comb begin
        w_enq_fire = '0;
        w_wr_ptr   = '0;
        w_enq_num  = '0;
        for (int l = 0; l < NUM_OF_ENQ_PORT; l++) begin
            w_enq_fire[l] = w_enq_ready && io_wq.enq_valid[l];
            w_wr_ptr[l]   = r_tail + PTR_WIDTH'(w_enq_num);
            w_enq_num     = w_enq_num + CNT_WIDTH'(w_enq_fire[l]);
        end
    end

    // Drain group: stop at the first entry that re-writes an earlier index of the group with a
    // partial mask, because the RAM would merge it in the wrong order within one cycle.
    always_comb begin
        logic v_stop;
        v_stop      = !w_drain_state;
        w_emit      = '0;
        w_rd_ptr    = '0;
        w_drain_num = '0;
        for (int k = 0; k < NUM_OF_WRITE_PORT; k++) begin
            w_rd_ptr[k] = r_head + PTR_WIDTH'(k);
        end
        for (int k = 0; k < NUM_OF_WRITE_PORT; k++) begin
            if (CNT_WIDTH'(k) >= r_count) v_stop = 1'b1;
            for (int j = 0; j < k; j++) begin
                if ((r_q_idx[w_rd_ptr[j]] == r_q_idx[w_rd_ptr[k]]) &&
                    (r_q_mask[w_rd_ptr[k]] != '1)) begin
                    v_stop = 1'b1;
                end
            end
            w_emit[k]   = !v_stop;
            w_drain_num = w_drain_num + CNT_WIDTH'(w_emit[k]);
        end
    end

    // NOTE: queue storage has no reset; head, tail and count alone decide which entries are live.
    always_ff @(posedge clock) begin
        for (int l = 0; l < NUM_OF_ENQ_PORT; l++) begin
            if (w_enq_fire[l]) begin
                r_q_idx[w_wr_ptr[l]]  <= io_wq.enq_idx[l];
                r_q_data[w_wr_ptr[l]] <= io_wq.enq_data[l];
                r_q_mask[w_wr_ptr[l]] <= io_wq.enq_mask[l];
            end
        end
    end

    assign w_clear_last = (r_clear_ptr + CLR_WIDTH'(NUM_OF_WRITE_PORT)) >= CLR_WIDTH'(RAM_DEPTH);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_clear_ptr <= '0;
        end else begin
            r_head  <= r_head + PTR_WIDTH'(w_drain_num);
            r_tail  <= r_tail + PTR_WIDTH'(w_enq_num);
            r_count <= r_count + w_enq_num - w_drain_num;
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (r_count == '0) begin
                        r_state     <= ST_CLEAR;
                        r_clear_ptr <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_clear_ptr <= r_clear_ptr + CLR_WIDTH'(NUM_OF_WRITE_PORT);
                    if (w_clear_last) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        io_wq.w_en      = '0;
        io_wq.w_ram_idx = '0;
        io_wq.w_data    = '0;
        io_wq.w_mask    = '0;
        if (r_state == ST_CLEAR) begin
            for (int k = 0; k < NUM_OF_WRITE_PORT; k++) begin
                io_wq.w_en[k]      = (r_clear_ptr + CLR_WIDTH'(k)) < CLR_WIDTH'(RAM_DEPTH);
                io_wq.w_ram_idx[k] = RAM_IDX_WIDTH'(r_clear_ptr + CLR_WIDTH'(k));
                io_wq.w_mask[k]    = '1;
            end
        end else begin
            for (int k = 0; k < NUM_OF_WRITE_PORT; k++) begin
                io_wq.w_en[k]      = w_emit[k];
                io_wq.w_ram_idx[k] = r_q_idx[w_rd_ptr[k]];
                io_wq.w_data[k]    = r_q_data[w_rd_ptr[k]];
                io_wq.w_mask[k]    = r_q_mask[w_rd_ptr[k]];
            end
        end
    end

    assign io_wq.enq_ready = w_enq_ready;
    assign clear_done      = (r_state == ST_DONE);
    assign busy            = (r_state != ST_IDLE);
    assign count           = r_count;

`ifdef LVTRAM_WQ_PERF_EN
    logic [31:0] r_conflict_cycles;
    logic [31:0] r_full_cycles;
    logic        w_conflict_cut;

    // Fewer than the full port count emitted while more entries wait means the index rule cut it.
    assign w_conflict_cut = w_drain_state &&
                            (w_drain_num < CNT_WIDTH'(NUM_OF_WRITE_PORT)) &&
                            (r_count > w_drain_num);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_conflict_cycles <= '0;
            r_full_cycles     <= '0;
        end else begin
            if (w_conflict_cut && (r_conflict_cycles != '1))
                r_conflict_cycles <= r_conflict_cycles + 32'd1;
            if ((r_count == CNT_WIDTH'(QUEUE_DEPTH)) && (r_full_cycles != '1))
                r_full_cycles <= r_full_cycles + 32'd1;
        end
    end

    assign conflict_cycles = r_conflict_cycles;
    assign full_cycles     = r_full_cycles;
`endif

endmodule
